ex_alu_unit: RTL and testbench

Execute-stage ALU that consumes the 4-bit `aluOp` code from the ALU control decoder together with two register operands and produces a registered result. Single-cycle ops complete with one-cycle latency; shifts run iteratively one bit per cycle to keep the datapath small. Uses a valid/ready handshake on both sides so the pipeline can stall it, and a flush input for branch redirects.

---
 rtl/ex_alu_unit.sv | 177 +++++++++++++++++
 tb/tb_ex_alu_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with a registered result and an iterative 1-bit/cycle shifter.
// Ports: clk, rst_n, flush; in_valid/in_ready + alu_op, op_a, op_b; out_valid/out_ready + result, zero, illegal.
module ex_alu_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               zero,
  output logic               illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1001;
  localparam logic [3:0] OP_NEQ  = 4'b1010;
  localparam logic [3:0] OP_GE   = 4'b1100;
  localparam logic [3:0] OP_GEU  = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                illegal_q, illegal_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     acc_q, acc_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                sh_right_q, sh_right_d;
  logic                sh_arith_q, sh_arith_d;

  logic                accept;
  logic                is_shift;
  logic                alu_ill;
  logic [XLEN-1:0]     alu_res;
  logic [XLEN-1:0]     acc_sh;
  logic [SHAMT_W-1:0]  shamt;
  logic                lt_s, lt_u, eq;

  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  assign shamt = op_b[SHAMT_W-1:0];
  assign lt_s  = $signed(op_a) < $signed(op_b);
  assign lt_u  = op_a < op_b;
  assign eq    = op_a == op_b;

  // in_ready never looks at in_valid, only at state, flush and out_ready
  assign in_ready = !flush &&
    ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // SRA shifts the sign bit back in; SRL and SLL shift in zero
  assign acc_sh = sh_right_q
    ? {sh_arith_q & acc_q[XLEN-1], acc_q[XLEN-1:1]}
    : {acc_q[XLEN-2:0], 1'b0};

  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (alu_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_SLT:  alu_res = lt_s ? ONE : '0;
      OP_SLTU: alu_res = lt_u ? ONE : '0;
      OP_GE:   alu_res = lt_s ? '0 : ONE;
      OP_GEU:  alu_res = lt_u ? '0 : ONE;
      OP_EQ:   alu_res = eq ? ONE : '0;
      OP_NEQ:  alu_res = eq ? '0 : ONE;
      // shamt 0 finishes immediately with op_a unchanged
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_res  = op_a;
        is_shift = 1'b1;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sh_right_d  = sh_right_q;
    sh_arith_d  = sh_arith_q;
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == S_SHIFT): begin
          acc_d = acc_sh;
          cnt_d = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
            result_d    = acc_sh;
            illegal_d   = 1'b0;
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
          end
        end
        default: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              acc_d       = op_a;
              cnt_d       = shamt;
              sh_right_d  = alu_op[2];
              sh_arith_d  = alu_op[3];
              state_d     = S_SHIFT;
              out_valid_d = 1'b0;
            end else begin
              result_d    = alu_res;
              illegal_d   = alu_ill;
              state_d     = S_HOLD;
              out_valid_d = 1'b1;
            end
          end else if ((state_q == S_HOLD) && out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sh_right_q  <= 1'b0;
      sh_arith_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sh_right_q  <= sh_right_d;
      sh_arith_q  <= sh_arith_d;
    end
  end

  assign result    = result_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed testbench for ex_alu_unit.
// Drives op sequences after each edge and checks outputs 1ns later.
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_alu_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  logic [3:0]  cmp_op [6];
  logic [31:0] cmp_exp [6];

  initial begin
    cmp_op[0] = 4'b0010; cmp_exp[0] = 32'd1;
    cmp_op[1] = 4'b0011; cmp_exp[1] = 32'd0;
    cmp_op[2] = 4'b1100; cmp_exp[2] = 32'd0;
    cmp_op[3] = 4'b1110; cmp_exp[3] = 32'd1;
    cmp_op[4] = 4'b1001; cmp_exp[4] = 32'd0;
    cmp_op[5] = 4'b1010; cmp_exp[5] = 32'd1;

    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    alu_op = 4'b0000;
    op_a = '0;
    op_b = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    #13;
    rst_n = 1'b1;
    tick();

    // ADD overflow wraps, then SUB back-to-back
    drive(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    tick();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_zero", {31'b0, zero}, 32'd0);
    chk("hold_in_ready", {31'b0, in_ready}, 32'd1);
    drive(4'b1000, 32'd5, 32'd5);
    tick();
    chk("sub_valid", {31'b0, out_valid}, 32'd1);
    chk("sub_result", result, 32'd0);
    chk("sub_zero", {31'b0, zero}, 32'd1);

    // compares, one per cycle
    for (int i = 0; i < 6; i++) begin
      drive(cmp_op[i], 32'hFFFF_FFFF, 32'h0000_0001);
      tick();
      chk($sformatf("cmp_%0d_result", i), result, cmp_exp[i]);
      chk($sformatf("cmp_%0d_valid", i), {31'b0, out_valid}, 32'd1);
    end
    idle();
    chk("drain_idle", {31'b0, out_valid}, 32'd0);

    // SRA by 31; operand changes after accept must not matter
    drive(4'b1101, 32'h8000_0000, 32'd31);
    tick();
    in_valid = 1'b0;
    op_a = 32'h0000_1234;
    op_b = 32'd3;
    chk("sra_busy_0", {31'b0, in_ready}, 32'd0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("sra_busy_%0d", k),
          {30'b0, in_ready, out_valid}, 32'd0);
    end
    tick();
    chk("sra_valid", {31'b0, out_valid}, 32'd1);
    chk("sra_result", result, 32'hFFFF_FFFF);
    idle();

    // SLL shamt 0 completes in one cycle
    drive(4'b0001, 32'd1, 32'd0);
    tick();
    chk("sll0_valid", {31'b0, out_valid}, 32'd1);
    chk("sll0_result", result, 32'd1);
    idle();

    // SLL by 4 takes four cycles
    drive(4'b0001, 32'd1, 32'd4);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("sll4_pending", {31'b0, out_valid}, 32'd0);
    tick();
    chk("sll4_valid", {31'b0, out_valid}, 32'd1);
    chk("sll4_result", result, 32'h0000_0010);
    idle();

    // backpressure on OR, then drain and accept ADD together
    out_ready = 1'b0;
    drive(4'b0110, 32'h0000_00F0, 32'h0000_000F);
    tick();
    drive(4'b0000, 32'd3, 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_%0d_result", k), result, 32'h0000_00FF);
      chk($sformatf("bp_%0d_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp_add_result", result, 32'd7);
    chk("bp_add_valid", {31'b0, out_valid}, 32'd1);
    idle();

    // flush during SRL by 10 at cycle 4
    drive(4'b0101, 32'h0000_0400, 32'd10);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_idle_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_result_kept", result, 32'd7);
    for (int k = 0; k < 10; k++) tick();
    chk("flush_no_result", {31'b0, out_valid}, 32'd0);
    chk("flush_result_same", result, 32'd7);

    // illegal ops, then a legal op clears the flag
    drive(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    chk("ill_valid", {31'b0, out_valid}, 32'd1);
    chk("ill_result", result, 32'd0);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    drive(4'b1011, 32'd1, 32'd1);
    tick();
    chk("ill1011_flag", {31'b0, illegal}, 32'd1);
    chk("ill1011_result", result, 32'd0);
    drive(4'b0000, 32'd2, 32'd2);
    tick();
    chk("legal_result", result, 32'd4);
    chk("legal_flag", {31'b0, illegal}, 32'd0);
    idle();

    // reset mid-shift aborts asynchronously
    drive(4'b0101, 32'hFFFF_0000, 32'd20);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_illegal", {31'b0, illegal}, 32'd0);
    chk("arst_zero", {31'b0, zero}, 32'd1);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) tick();
    chk("arst_no_result", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
